// File: rtl/ustc_pkg.sv
// Shared widths, out_ctrl bit positions and FSM state encoding for the
// sparse encoder slice.
package ustc_pkg;

  localparam int DW_DATA = 8;
  localparam int DW_ROW  = 4;
  localparam int DW_COL  = 4;
  localparam int DW_CTRL = 4;
  localparam int DW_A    = DW_DATA + DW_ROW + DW_COL;

  localparam int CTRL_FIRST    = 0;
  localparam int CTRL_LAST     = 1;
  localparam int CTRL_LAST_ROW = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    SCAN   = 2'd2,
    FINISH = 2'd3
  } state_t;

endpackage

// File: rtl/ustc_nz_pick.sv
// Combinational find-first-set over a K-bit nonzero mask: lowest set column,
// whether any bit is set, and whether exactly one bit is set.
module ustc_nz_pick #(
  parameter int K  = 16,
  parameter int CW = 4
) (
  input  logic [K-1:0]  mask,
  output logic [CW-1:0] col,
  output logic          found,
  output logic          last
);

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    col = '0;
    for (int i = K - 1; i >= 0; i--) begin
      if (mask[i]) col = CW'(i);
    end
  end

  assign found = |mask;
  assign last  = found && ((mask & (mask - 1'b1)) == '0);

endmodule

// File: rtl/ustc_sparse_encoder.sv
// Dense-row to sparse-entry encoder: each accepted row is reduced to a nonzero
// mask and drained one {data,row,col} entry per out handshake.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | waiting for the next dense row
// SCAN   | emitting the held row's nonzeros, lowest column first
// FINISH | one-cycle done pulse, nnz_total final
module ustc_sparse_encoder
  import ustc_pkg::*;
#(
  parameter int M       = 16,
  parameter int K       = 16,
  parameter int DW_DATA = ustc_pkg::DW_DATA,
  parameter int DW_ROW  = ustc_pkg::DW_ROW,
  parameter int DW_COL  = ustc_pkg::DW_COL,
  parameter int DW_CTRL = ustc_pkg::DW_CTRL,
  parameter int DW_A    = DW_DATA + DW_ROW + DW_COL
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [K*DW_DATA-1:0] in_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DW_A-1:0]      out_a,
  output logic [DW_CTRL-1:0]   out_ctrl,
  output logic                 done,
  output logic [8:0]           nnz_total
);

  state_t               state, state_nx;
  logic [K-1:0]         mask, in_nz;
  logic [K*DW_DATA-1:0] data;
  logic [DW_ROW-1:0]    row_cur, row_next;
  logic                 first;
  logic [8:0]           nnz;
  logic [DW_COL-1:0]    col;
  logic                 found, last;
  logic                 scanning, last_row, row_end, hs_in, hs_out;
  logic [DW_DATA-1:0]   elem;

  ustc_nz_pick #(.K(K), .CW(DW_COL)) u_pick (
    .mask  (mask),
    .col   (col),
    .found (found),
    .last  (last)
  );

  always_comb begin
    in_nz = '0;
    for (int c = 0; c < K; c++) begin
      in_nz[c] = |in_row[c*DW_DATA +: DW_DATA];
    end
  end

  assign scanning  = (state == SCAN);
  assign last_row  = (row_cur == DW_ROW'(M - 1));
  assign out_valid = scanning && found;
  assign hs_out    = out_valid && out_ready;
  // A row ends on its last handshake, or immediately if it had no nonzeros.
  assign row_end   = scanning && (!found || (out_ready && last));
  assign in_ready  = (state == LOAD) || (row_end && !last_row);
  assign hs_in     = in_valid && in_ready;
  assign elem      = data[int'(col)*DW_DATA +: DW_DATA];
  assign out_a     = out_valid ? {elem, row_cur, col} : '0;
  assign done      = (state == FINISH);
  assign nnz_total = nnz;

  always_comb begin
    out_ctrl = '0;
    if (out_valid) begin
      out_ctrl[CTRL_FIRST]    = first;
      out_ctrl[CTRL_LAST]     = last;
      out_ctrl[CTRL_LAST_ROW] = last_row;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (start) state_nx = LOAD;
      LOAD:   if (in_valid) state_nx = SCAN;
      SCAN: begin
        if (row_end) begin
          if (last_row)      state_nx = FINISH;
          else if (in_valid) state_nx = SCAN;
          else               state_nx = LOAD;
        end
      end
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      mask     <= '0;
      data     <= '0;
      row_cur  <= '0;
      row_next <= '0;
      first    <= 1'b0;
      nnz      <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        nnz      <= '0;
        row_next <= '0;
      end
      if (hs_in) begin
        data     <= in_row;
        mask     <= in_nz;
        row_cur  <= row_next;
        row_next <= row_next + 1'b1;
        first    <= 1'b1;
      end else if (hs_out) begin
        mask  <= mask & ~(K'(1) << col);
        first <= 1'b0;
      end
      if (hs_out) nnz <= nnz + 1'b1;
    end
  end

endmodule

// File: tb/tb_ustc_sparse_encoder.sv
// Directed bench for ustc_sparse_encoder: identity, sparse row, all-zero,
// dense with back-pressure, mid-matrix reset and ignored start.
module tb_ustc_sparse_encoder;

  localparam int M = 16;
  localparam int K = 16;

  logic         clk;
  logic         reset;
  logic         start;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_row;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  out_a;
  logic [3:0]   out_ctrl;
  logic         done;
  logic [8:0]   nnz_total;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mat [M][K];
  logic [19:0] entries [$];
  int stall_err, valid_cycles, done_cnt, acc_iter, done_iter, aborted;
  logic [8:0] nnz_done;

  ustc_sparse_encoder #(.M(M), .K(K)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_row    (in_row),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_ctrl  (out_ctrl),
    .done      (done),
    .nnz_total (nnz_total)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic fill(input logic [7:0] v);
    for (int r = 0; r < M; r++)
      for (int c = 0; c < K; c++) mat[r][c] = v;
  endtask

  // Runs one matrix through the DUT; inputs change and outputs are sampled
  // around the falling edge.
  task automatic run_matrix(input bit toggle, input int abort_row, input int glitch_iter,
                            input int budget);
    int row_ptr, row_seen;
    bit prev_stall;
    logic [15:0] prev_a;
    logic [3:0]  prev_c;
    entries.delete();
    stall_err = 0; valid_cycles = 0; done_cnt = 0; acc_iter = -1; done_iter = -1;
    aborted = 0; nnz_done = '0; row_ptr = 0; row_seen = 0; prev_stall = 0;
    prev_a = '0; prev_c = '0;
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int it = 0; it < budget; it++) begin
      out_ready = toggle ? (it % 2 == 0) : 1'b1;
      start     = (it == glitch_iter);
      in_valid  = (row_ptr < M);
      if (row_ptr < M)
        for (int c = 0; c < K; c++) in_row[c*8 +: 8] = mat[row_ptr][c];
      #1;
      if (prev_stall && (!out_valid || out_a !== prev_a || out_ctrl !== prev_c))
        stall_err++;
      if (out_valid) valid_cycles++;
      if (abort_row >= 0 && out_valid && out_a[7:4] == abort_row[3:0] && row_seen == 2) begin
        reset = 1'b0; aborted = 1;
        break;
      end
      if (out_valid && out_ready) begin
        entries.push_back({out_a, out_ctrl});
        if (out_a[7:4] == abort_row[3:0]) row_seen++;
      end
      if (in_valid && in_ready) begin
        if (acc_iter < 0) acc_iter = it;
        row_ptr++;
      end
      prev_stall = out_valid && !out_ready;
      prev_a = out_a; prev_c = out_ctrl;
      if (done) begin
        done_cnt++; done_iter = it; nnz_done = nnz_total;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_row = '1;
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_a !== 16'h0) begin failures++; $display("FAIL rst_out_a got=%h exp=0000", out_a); end
    checks++; if (out_ctrl !== 4'h0) begin failures++; $display("FAIL rst_out_ctrl got=%h exp=0", out_ctrl); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", done); end
    checks++; if (nnz_total !== 9'd0) begin failures++; $display("FAIL rst_nnz got=%0d exp=0", nnz_total); end
    reset = 1'b1;
    // Idle with in_valid held and no start: nothing may be accepted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
        failures++; $display("FAIL idle_no_accept got=%b%b exp=00", in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_identity;
    logic [19:0] exp;
    fill(8'h00);
    for (int i = 0; i < M; i++) mat[i][i] = 8'h01;
    run_matrix(1'b0, -1, -1, 400);
    checks++; if (entries.size() != 16) begin failures++; $display("FAIL id_count got=%0d exp=16", entries.size()); end
    for (int i = 0; i < 16; i++) begin
      exp = {8'h01, 4'(i), 4'(i), (i == 15) ? 4'h7 : 4'h3};
      if (i < entries.size()) begin
        checks++; if (entries[i] !== exp) begin failures++; $display("FAIL id_entry%0d got=%h exp=%h", i, entries[i], exp); end
      end
    end
    checks++; if (done_cnt != 1) begin failures++; $display("FAIL id_done got=%0d exp=1", done_cnt); end
    checks++; if (nnz_done !== 9'd16) begin failures++; $display("FAIL id_nnz got=%0d exp=16", nnz_done); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || nnz_total !== 9'd16) begin
      failures++; $display("FAIL id_hold got=%b/%0d exp=0/16", done, nnz_total);
    end
  endtask

  task automatic test_sparse_row;
    fill(8'h00);
    mat[0][0] = 8'd5; mat[0][3] = 8'd7; mat[0][15] = 8'd9;
    run_matrix(1'b0, -1, -1, 400);
    checks++; if (entries.size() != 3) begin failures++; $display("FAIL sp_count got=%0d exp=3", entries.size()); end
    if (entries.size() == 3) begin
      checks++; if (entries[0] !== {16'h0500, 4'h1}) begin failures++; $display("FAIL sp_e0 got=%h exp=05001", entries[0]); end
      checks++; if (entries[1] !== {16'h0703, 4'h0}) begin failures++; $display("FAIL sp_e1 got=%h exp=07030", entries[1]); end
      checks++; if (entries[2] !== {16'h090F, 4'h2}) begin failures++; $display("FAIL sp_e2 got=%h exp=090f2", entries[2]); end
    end
    checks++; if (done_cnt != 1 || nnz_done !== 9'd3) begin
      failures++; $display("FAIL sp_done got=%0d/%0d exp=1/3", done_cnt, nnz_done);
    end
  endtask

  task automatic test_all_zero;
    fill(8'h00);
    run_matrix(1'b0, -1, -1, 400);
    checks++; if (valid_cycles != 0) begin failures++; $display("FAIL zero_valid got=%0d exp=0", valid_cycles); end
    checks++; if (done_cnt != 1 || nnz_done !== 9'd0) begin
      failures++; $display("FAIL zero_done got=%0d/%0d exp=1/0", done_cnt, nnz_done);
    end
    // Accept cycle, then M single-cycle SCANs, then FINISH.
    checks++; if (done_iter - acc_iter != M + 1) begin
      failures++; $display("FAIL zero_latency got=%0d exp=%0d", done_iter - acc_iter, M + 1);
    end
  endtask

  task automatic test_back_to_back;
    logic [19:0] exp;
    int bad;
    fill(8'hFF);
    run_matrix(1'b1, -1, -1, 1500);
    checks++; if (entries.size() != 256) begin failures++; $display("FAIL dense_count got=%0d exp=256", entries.size()); end
    bad = 0;
    for (int n = 0; n < entries.size() && n < 256; n++) begin
      exp[19:4] = {8'hFF, 4'(n / 16), 4'(n % 16)};
      exp[3:0]  = {1'b0, (n / 16) == 15, (n % 16) == 15, (n % 16) == 0};
      if (entries[n] !== exp) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL dense_order got=%0d exp=0 wrong entries", bad); end
    checks++; if (stall_err != 0) begin failures++; $display("FAIL dense_stall got=%0d exp=0", stall_err); end
    checks++; if (nnz_done !== 9'd256) begin failures++; $display("FAIL dense_nnz got=%0d exp=256", nnz_done); end
  endtask

  task automatic test_reset_mid;
    int dseen;
    fill(8'hFF);
    run_matrix(1'b0, 5, -1, 1500);
    checks++; if (aborted != 1 || entries.size() != 82) begin
      failures++; $display("FAIL mid_abort_point got=%0d/%0d exp=1/82", aborted, entries.size());
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || out_a !== 16'h0 || out_ctrl !== 4'h0) begin
      failures++; $display("FAIL mid_outputs got=%b/%h/%h exp=0/0000/0", out_valid, out_a, out_ctrl);
    end
    checks++; if (in_ready !== 1'b0 || done !== 1'b0 || nnz_total !== 9'd0) begin
      failures++; $display("FAIL mid_idle got=%b/%b/%0d exp=0/0/0", in_ready, done, nnz_total);
    end
    reset = 1'b1;
    dseen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dseen++;
    end
    checks++; if (dseen != 0) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", dseen); end
    fill(8'h00);
    for (int i = 0; i < M; i++) mat[i][i] = 8'h01;
    run_matrix(1'b0, -1, -1, 400);
    checks++; if (entries.size() != 16 || nnz_done !== 9'd16 || done_cnt != 1) begin
      failures++; $display("FAIL mid_restart got=%0d/%0d/%0d exp=16/16/1", entries.size(), nnz_done, done_cnt);
    end
  endtask

  task automatic test_start_ignored;
    fill(8'h00);
    for (int i = 0; i < M; i++) mat[i][i] = 8'h01;
    run_matrix(1'b0, -1, 5, 400);
    checks++; if (entries.size() != 16) begin failures++; $display("FAIL glitch_count got=%0d exp=16", entries.size()); end
    if (entries.size() == 16) begin
      checks++; if (entries[7] !== {16'h0177, 4'h3}) begin failures++; $display("FAIL glitch_e7 got=%h exp=01773", entries[7]); end
    end
    checks++; if (done_cnt != 1 || nnz_done !== 9'd16) begin
      failures++; $display("FAIL glitch_nnz got=%0d/%0d exp=1/16", done_cnt, nnz_done);
    end
  endtask

  initial begin
    in_row = '0;
    test_reset;
    test_identity;
    test_sparse_row;
    test_all_zero;
    test_back_to_back;
    test_reset_mid;
    test_start_ignored;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
